// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory request in flight,
// and holds the fetched PC/instruction pair until downstream accepts it or a redirect drops it.
module fetch_unit #(
    parameter int unsigned PC_WIDTH   = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_STEP    = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  valid_o,
    output logic [PC_WIDTH-1:0]   pco,
    output logic [DATA_WIDTH-1:0] instro
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic                    kill_q, kill_d;
    logic [PC_WIDTH-1:0]     pco_q, pco_d;
    logic [DATA_WIDTH-1:0]   instro_q, instro_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_WIDTH'(RESET_PC);
            kill_q   <= 1'b0;
            pco_q    <= '0;
            instro_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            pco_q    <= pco_d;
            instro_q <= instro_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        pco_d    = pco_q;
        instro_d = instro_q;

        if (redirect) begin
            // A request already on the bus cannot be recalled, so its response is marked for discard.
            pc_d = redirect_pc;
            case (state_q)
                S_ISSUE: begin
                    kill_d  = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = S_ISSUE;
            endcase
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ISSUE;
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_ISSUE;
                        end else begin
                            pco_d    = pc_q;
                            instro_d = imem_rdata;
                            state_d  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc_d    = pc_q + PC_WIDTH'(PC_STEP);
                        state_d = S_ISSUE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign imem_req  = (state_q == S_ISSUE);
    assign imem_addr = imem_req ? pc_q : '0;
    assign valid_o   = (state_q == S_HOLD) && !redirect;
    assign pco       = pco_q;
    assign instro    = instro_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory responder, program-order scoreboard,
// directed scenarios followed by randomized stall/redirect traffic.
module tb_fetch_unit;
    localparam int PCW = 9;
    localparam int DW  = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           stall = 1'b0;
    logic           redirect = 1'b0;
    logic [PCW-1:0] redirect_pc = '0;
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_rvalid = 1'b0;
    logic [DW-1:0]  imem_rdata = '0;
    logic           valid_o;
    logic [PCW-1:0] pco;
    logic [DW-1:0]  instro;

    fetch_unit #(.PC_WIDTH(PCW), .DATA_WIDTH(DW), .PC_STEP(4), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .valid_o(valid_o), .pco(pco), .instro(instro)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int deliveries = 0;
    int lat_fixed = 1;
    bit stray_req = 1'b0;
    logic [PCW-1:0] exp_q[$];
    logic [DW-1:0]  mem [128];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic wait_req(output logic [PCW-1:0] a, output int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req && n < 60);
        if (!imem_req) chk("req_timeout", 32'd0, 32'd1);
        a = imem_addr;
        c = cyc;
        $display("req addr=0x%03h cycle=%0d", a, c);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_o && n < 60);
        if (!valid_o) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic model_redirect(input logic [PCW-1:0] tgt);
        exp_q.delete();
        exp_q.push_back(tgt);
    endtask

    // Memory: one request at a time, response after a programmable number of cycles.
    initial begin : responder
        bit pending = 1'b0;
        int cnt = 0;
        logic [PCW-1:0] raddr = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (stray_req) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEADBEEF;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem[raddr[8:2]];
                    pending     = 1'b0;
                end
            end
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
            end else if (imem_req) begin
                chk("one_outstanding", {31'd0, pending}, 32'd0);
                pending = 1'b1;
                raddr   = imem_addr;
                cnt     = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
            end
        end
    end

    // Scoreboard: every handoff must be the next instruction in program order.
    initial begin : monitor
        logic [PCW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (redirect) chk("valid_during_redirect", {31'd0, valid_o}, 32'd0);
                if (valid_o && !stall) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("deliver_pc", {23'd0, pco}, {23'd0, e});
                        chk("deliver_instr", instro, mem[e[8:2]]);
                        $display("handoff pco=0x%03h instro=0x%08h expected_pc=0x%03h", pco, instro, e);
                        exp_q.push_back(e + 9'd4);
                        deliveries++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [PCW-1:0] a;
        int c0, c1, h, rel;
        logic [6:0] w;

        for (int i = 0; i < 128; i++)
            mem[i] = (i < 8) ? (32'hA0000000 | (i * 4)) : $urandom;
        exp_q.push_back(9'h000);

        #1 rst = 1'b1;
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", {23'd0, imem_addr}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_pco", {23'd0, pco}, 32'd0);
        chk("rst_instro", instro, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Sequential fetch, latency 1
        wait_req(a, c0);
        chk("seq_addr0", {23'd0, a}, 32'h000);
        wait_req(a, c1);
        chk("seq_addr1", {23'd0, a}, 32'h004);
        chk("seq_spacing", c1 - c0, 32'd3);
        stall = 1'b1;

        // Park 0x004 in HOLD under stall
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, valid_o}, 32'd1);
            chk("hold_pco", {23'd0, pco}, 32'h004);
            chk("hold_instr", instro, 32'hA0000004);
            chk("hold_noreq", {31'd0, imem_req}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 stall = 1'b0;
        h = cyc;
        wait_req(a, c0);
        chk("after_stall_addr", {23'd0, a}, 32'h008);
        chk("after_stall_cycle", c0, h + 1);

        // Redirect while a slow request is outstanding
        @(posedge clk);
        #1 lat_fixed = 4;
        wait_req(a, c0);
        chk("slow_addr", {23'd0, a}, 32'h00C);
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 9'h040;
        model_redirect(9'h040);
        @(posedge clk);
        #1 redirect = 1'b0;
        wait_req(a, c0);
        chk("kill_next_addr", {23'd0, a}, 32'h040);
        wait_valid();
        chk("kill_deliver_pc", {23'd0, pco}, 32'h040);

        // Redirect in HOLD with stall released the same cycle
        @(posedge clk);
        #1 stall = 1'b1;
        wait_valid();
        chk("park_pco", {23'd0, pco}, 32'h044);
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 9'h100;
        stall = 1'b0;
        model_redirect(9'h100);
        @(negedge clk);
        chk("hold_redirect_valid", {31'd0, valid_o}, 32'd0);
        @(posedge clk);
        #1 redirect = 1'b0;
        wait_req(a, c0);
        chk("hold_redirect_addr", {23'd0, a}, 32'h100);

        // PC wraparound
        @(posedge clk);
        #1 lat_fixed = 1;
        redirect = 1'b1;
        redirect_pc = 9'h1FC;
        model_redirect(9'h1FC);
        @(posedge clk);
        #1 redirect = 1'b0;
        wait_req(a, c0);
        chk("wrap_addr0", {23'd0, a}, 32'h1FC);
        wait_req(a, c0);
        chk("wrap_addr1", {23'd0, a}, 32'h000);

        // Asynchronous reset in the middle of WAIT, then a stray response
        @(posedge clk);
        #1 lat_fixed = 4;
        wait_req(a, c0);
        @(posedge clk);
        #3 rst = 1'b1;
        model_redirect(9'h000);
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("async_rst_pco", {23'd0, pco}, 32'd0);
        chk("async_rst_instro", instro, 32'd0);
        @(negedge clk);
        stray_req = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        #1 stray_req = 1'b0;
        wait_req(a, c0);
        chk("post_rst_addr", {23'd0, a}, 32'h000);
        chk("post_rst_cycle", c0, rel + 1);
        wait_valid();
        chk("post_rst_instr", instro, mem[0]);

        // Randomized stall/redirect traffic with random memory latency
        @(posedge clk);
        #1 lat_fixed = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            stall = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 29) == 0) begin
                w = 7'($urandom_range(0, 127));
                redirect = 1'b1;
                redirect_pc = ($urandom_range(0, 9) == 0) ? 9'h1FC : {w, 2'b00};
                model_redirect(redirect_pc);
                $display("redirect to 0x%03h cycle=%0d", redirect_pc, cyc);
            end else begin
                redirect = 1'b0;
            end
        end
        @(posedge clk);
        #1 redirect = 1'b0;
        stall = 1'b0;
        repeat (10) @(posedge clk);
        chk("progress", {31'd0, deliveries > 200}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
